nibble_sum_accumulator: RTL and testbench
=========================================

// Module: nibble_sum_accumulator
// PURPOSE
//  Downstream stage of the nibble adder. Consumes the stream of 4-bit sums through a
//  valid/ready handshake and accumulates WINDOW consecutive sums into one saturating
//  frame total. The total is then presented on a valid/ready output with a saturation flag.
//  It sits between the adder's registered sum and the uo_out pin mux.
// PARAMETERS
//  SUM_W   4   width of each incoming sum
//  ACC_W   8   accumulator and out_acc width; must be >= SUM_W
//  WINDOW  4   samples per frame; legal range 1..255
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous frame abort
//  in_valid   in   1      in_sum is valid
//  in_sum     in   SUM_W  sum from the adder stage
//  in_ready   out  1      registered; block can accept a sample
//  out_valid  out  1      registered; out_acc/out_sat/out_count hold a completed frame
//  out_ready  in   1      consumer takes the frame
//  out_acc    out  ACC_W  frame total, saturated
//  out_sat    out  1      1 if any add in the frame clamped
//  out_count  out  8      samples in the frame; equals WINDOW when out_valid=1
// BEHAVIOUR
//  - Reset: asserting rst_n low immediately forces the following, independent of clk:
//      * state = IDLE
//      * in_ready, out_valid, out_acc, out_sat, out_count = 0
//      * internal acc and cnt = 0
//    in_ready rises on the first clk edge after rst_n deasserts.
//  - Handshakes: accept = in_valid & in_ready; deliver = out_valid & out_ready.
//    in_valid is ignored while in_ready=0.
//  - FSM states: IDLE, ACCUM, DONE.
//    * IDLE, on accept:
//        acc = in_sum zero-extended; cnt = 1; sat = 0.
//        Go to DONE if WINDOW==1, else ACCUM.
//    * ACCUM, on accept:
//        acc = sat_add(acc, in_sum); cnt += 1.
//        Go to DONE when the new cnt == WINDOW.
//        No accept: hold all state.
//    * DONE: in_ready=0 and out_valid=1. out_acc, out_sat and out_count are stable until deliver.
//        On deliver: go to IDLE, clear out_valid, set in_ready=1 on the next cycle.
//  - Timing:
//    * in_ready is registered: next value = (next_state != DONE) & ~clear.
//      It drops in the same edge that enters DONE, so no sample is accepted after the
//      WINDOW-th one.
//    * out_valid rises on the clk edge that accepts the WINDOW-th sample (latency 1 cycle).
//    * out_acc is updated on that same edge.
//  - Saturation:
//    * sat_add is computed at ACC_W+1 bits.
//    * If the sum exceeds 2^ACC_W-1, acc = 2^ACC_W-1 and sat is set.
//    * sat is sticky for the rest of the frame.
//    * No wrap-around ever occurs.
//  - clear=1 has priority over accept and deliver in every state:
//    * next state = IDLE.
//    * acc, cnt, sat and out_valid are zeroed.
//    * in_ready is 0 for that cycle and returns to 1 on the following cycle.
//    * A frame in progress, or a pending result, is discarded with no out_valid pulse.
//  - Gaps: in_valid may drop for any number of cycles mid-frame; cnt and acc hold.
//  - DONE with in_valid=1 and out_ready=1: the result is delivered; the sample is NOT accepted.
//  - Reset mid-frame: partial frame lost; the next frame starts fresh from IDLE.
// TESTING
//  1. Defaults, out_ready=1; accept sums 3,5,7,9 back-to-back
//     -> out_valid=1 the edge after sum 9; out_acc=24, out_sat=0, out_count=4; out_valid=1 for exactly 1 cycle.
//  2. ACC_W=5; sums 15,15,15,15
//     -> out_acc=31, out_sat=1, out_count=4.
//     Follow with a frame of sums 1,1,1,1 -> out_acc=4, out_sat=0 (sat not carried over).
//  3. out_ready=0 for 6 cycles after a frame completes (sums 1,2,3,4)
//     -> out_acc=10 held, in_ready=0, in_valid pulses ignored.
//     Raise out_ready -> frame delivered; in_ready=1 the next cycle.
//  4. Accept 2 sums (8,8), then clear=1 for 1 cycle
//     -> no out_valid, in_ready=0 for 1 cycle.
//     Then sums 1,1,1,1 -> out_acc=4.
//  5. rst_n low for 1/2 cycle after 3 accepted sums
//     -> all outputs 0 immediately; in_ready=1 on the first edge after release.
//     Then a new frame of sums 2,2,2,2 -> out_acc=8.
//  6. WINDOW=1; in_valid with alternating gaps, sums 6,9
//     -> two frames, out_acc=6 then 9, each 1 cycle after its accept.

Source files
------------

// File: rtl/nibble_sum_accumulator.sv
// Accumulates WINDOW consecutive adder sums into one saturating frame total
// and presents the result on a valid/ready output with a sticky saturation flag.
module nibble_sum_accumulator #(
    parameter int SUM_W  = 4,
    parameter int ACC_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0]     WIN8    = 8'(WINDOW);
    localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic             out_sat_q, out_sat_d;
    logic [7:0]       out_count_q, out_count_d;

    logic             accept;
    logic             deliver;
    logic [ACC_W:0]   sum_ext;
    logic [7:0]       cnt_inc;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        // One extra bit lets overflow be detected before clamping.
        sum_ext     = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
        cnt_inc     = cnt_q + 8'd1;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d = ACC_W'(in_sum);
                        cnt_d = 8'd1;
                        sat_d = 1'b0;
                        if (WINDOW == 1) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            out_acc_d   = ACC_W'(in_sum);
                            out_sat_d   = 1'b0;
                            out_count_d = 8'd1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (sum_ext > ACC_MAX) begin
                            acc_d = '1;
                            sat_d = 1'b1;
                        end else begin
                            acc_d = sum_ext[ACC_W-1:0];
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == WIN8) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            out_acc_d   = acc_d;
                            out_sat_d   = sat_d;
                            out_count_d = cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (deliver) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Dropping ready on the edge that enters DONE blocks a (WINDOW+1)-th sample.
        in_ready_d = (state_d != DONE) & ~clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Bench for nibble_sum_accumulator: three configurations share one stimulus stream,
// each checked every cycle against a frame-level model plus directed literal values.
module tb_nibble_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_sum = 4'd0;
    logic       out_ready = 1'b1;

    logic       rdy0, rdy1, rdy2;
    logic       vld0, vld1, vld2;
    logic       sat0, sat1, sat2;
    logic [7:0] acc0, acc2;
    logic [4:0] acc1;
    logic [7:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_sum_accumulator #(.SUM_W(4), .ACC_W(8), .WINDOW(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(rdy0), .out_valid(vld0), .out_ready(out_ready),
        .out_acc(acc0), .out_sat(sat0), .out_count(cnt0));

    nibble_sum_accumulator #(.SUM_W(4), .ACC_W(5), .WINDOW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(rdy1), .out_valid(vld1), .out_ready(out_ready),
        .out_acc(acc1), .out_sat(sat1), .out_count(cnt1));

    nibble_sum_accumulator #(.SUM_W(4), .ACC_W(8), .WINDOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(rdy2), .out_valid(vld2), .out_ready(out_ready),
        .out_acc(acc2), .out_sat(sat2), .out_count(cnt2));

    int ACCW_T[3] = '{8, 5, 8};
    int WIN_T[3]  = '{4, 4, 1};

    // Frame-level model: running total, samples so far, pending result.
    int m_ready[3], m_valid[3], m_acc[3], m_cnt[3], m_sat[3];
    int m_oacc[3], m_osat[3], m_ocnt[3];

    function automatic int dut_rdy(int k);
        return (k == 0) ? int'(rdy0) : (k == 1) ? int'(rdy1) : int'(rdy2);
    endfunction
    function automatic int dut_vld(int k);
        return (k == 0) ? int'(vld0) : (k == 1) ? int'(vld1) : int'(vld2);
    endfunction
    function automatic int dut_acc(int k);
        return (k == 0) ? int'(acc0) : (k == 1) ? int'(acc1) : int'(acc2);
    endfunction
    function automatic int dut_sat(int k);
        return (k == 0) ? int'(sat0) : (k == 1) ? int'(sat1) : int'(sat2);
    endfunction
    function automatic int dut_cnt(int k);
        return (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(int k);
        int total;
        int maxv;
        maxv = (1 << ACCW_T[k]) - 1;
        if (clear) begin
            m_ready[k] = 0; m_valid[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        end else if (m_valid[k] != 0) begin
            if (out_ready) begin
                m_valid[k] = 0;
                m_ready[k] = 1;
            end
        end else begin
            if (m_ready[k] != 0 && in_valid) begin
                if (m_cnt[k] == 0) begin
                    m_acc[k] = int'(in_sum);
                    m_sat[k] = 0;
                end else begin
                    total = m_acc[k] + int'(in_sum);
                    if (total > maxv) begin
                        m_acc[k] = maxv;
                        m_sat[k] = 1;
                    end else begin
                        m_acc[k] = total;
                    end
                end
                m_cnt[k]++;
                if (m_cnt[k] == WIN_T[k]) begin
                    m_valid[k] = 1;
                    m_oacc[k]  = m_acc[k];
                    m_osat[k]  = m_sat[k];
                    m_ocnt[k]  = m_cnt[k];
                    m_cnt[k]   = 0;
                end
            end
            m_ready[k] = (m_valid[k] != 0) ? 0 : 1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_ready[k] = 0; m_valid[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
                m_oacc[k] = 0; m_osat[k] = 0; m_ocnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_in_ready", k), dut_rdy(k), m_ready[k]);
            chk($sformatf("d%0d_out_valid", k), dut_vld(k), m_valid[k]);
            if (m_valid[k] != 0) begin
                chk($sformatf("d%0d_out_acc", k), dut_acc(k), m_oacc[k]);
                chk($sformatf("d%0d_out_sat", k), dut_sat(k), m_osat[k]);
                chk($sformatf("d%0d_out_count", k), dut_cnt(k), WIN_T[k]);
            end
        end
    end

    // Called just after a falling edge; returns just after the edge that follows acceptance.
    task automatic send(input int k, input int s);
        int n;
        n = 0;
        while (dut_rdy(k) == 0 && n < 50) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("send_timeout_d%0d", k), 0, 1);
        in_valid = 1'b1;
        in_sum   = 4'(s);
        @(negedge clk);
        $display("tx dut%0d sum=%0d", k, s);
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    initial begin
        int seq1[4];
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(rdy0), 0);
        chk("reset_out_valid", int'(vld0), 0);
        chk("reset_out_acc", int'(acc0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(rdy0), 1);

        // Test 1: 3,5,7,9 back-to-back
        seq1 = '{3, 5, 7, 9};
        foreach (seq1[i]) send(0, seq1[i]);
        in_valid = 1'b0;
        chk("t1_valid", int'(vld0), 1);
        chk("t1_acc", int'(acc0), 24);
        chk("t1_model_acc", m_oacc[0], 24);
        chk("t1_sat", int'(sat0), 0);
        chk("t1_count", int'(cnt0), 4);
        @(negedge clk);
        chk("t1_valid_one_cycle", int'(vld0), 0);

        // Test 2: saturation in the ACC_W=5 instance, then a clean frame
        do_clear();
        for (int i = 0; i < 4; i++) send(1, 15);
        in_valid = 1'b0;
        chk("t2_valid", int'(vld1), 1);
        chk("t2_acc", int'(acc1), 31);
        chk("t2_model_acc", m_oacc[1], 31);
        chk("t2_sat", int'(sat1), 1);
        chk("t2_count", int'(cnt1), 4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(1, 1);
        in_valid = 1'b0;
        chk("t2b_acc", int'(acc1), 4);
        chk("t2b_sat", int'(sat1), 0);
        @(negedge clk);

        // Test 3: back-pressure holds the result and blocks input
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, i);
        for (int c = 0; c < 6; c++) begin
            in_valid = (c % 2 == 0);
            in_sum   = 4'd7;
            chk("t3_hold_valid", int'(vld0), 1);
            chk("t3_hold_acc", int'(acc0), 10);
            chk("t3_hold_ready", int'(rdy0), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_delivered", int'(vld0), 0);
        chk("t3_ready_back", int'(rdy0), 1);

        // Test 4: clear aborts a partial frame
        do_clear();
        send(0, 8);
        send(0, 8);
        do_clear();
        chk("t4_no_valid", int'(vld0), 0);
        chk("t4_ready_low", int'(rdy0), 0);
        @(negedge clk);
        chk("t4_ready_back", int'(rdy0), 1);
        chk("t4_still_no_valid", int'(vld0), 0);
        for (int i = 0; i < 4; i++) send(0, 1);
        in_valid = 1'b0;
        chk("t4_acc", int'(acc0), 4);
        @(negedge clk);

        // Test 5: asynchronous reset mid-frame
        do_clear();
        for (int i = 0; i < 3; i++) send(0, 5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", int'(rdy0), 0);
        chk("t5_rst_valid", int'(vld0), 0);
        chk("t5_rst_acc", int'(acc0), 0);
        chk("t5_rst_sat", int'(sat0), 0);
        chk("t5_rst_count", int'(cnt0), 0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_pre_edge", int'(rdy0), 0);
        @(negedge clk);
        chk("t5_ready_post_edge", int'(rdy0), 1);
        for (int i = 0; i < 4; i++) send(0, 2);
        in_valid = 1'b0;
        chk("t5_acc", int'(acc0), 8);
        @(negedge clk);

        // Test 6: WINDOW=1 instance with gaps
        do_clear();
        send(2, 6);
        in_valid = 1'b0;
        chk("t6a_valid", int'(vld2), 1);
        chk("t6a_acc", int'(acc2), 6);
        chk("t6a_count", int'(cnt2), 1);
        @(negedge clk);
        chk("t6a_one_cycle", int'(vld2), 0);
        @(negedge clk);
        send(2, 9);
        in_valid = 1'b0;
        chk("t6b_valid", int'(vld2), 1);
        chk("t6b_acc", int'(acc2), 9);
        chk("t6b_model_acc", m_oacc[2], 9);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
